// File: rtl/cam_i2c_cmd_sequencer.sv
// Expands a camera register-table instruction into a burst of 16-bit I2C writes,
// with per-word retry on NACK/timeout and a sticky error report.
module cam_i2c_cmd_sequencer #(
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         sysClk,
  input  logic         sysRst_n,
  input  logic [7:0]   reg_addr,
  input  logic [127:0] reg_data,
  input  logic         instr_valid,
  output logic         instr_ready,
  output logic [7:0]   cam_i2c_addr,
  output logic [15:0]  cam_i2c_data,
  output logic         cam_id,
  output logic         cmd_valid,
  input  logic         cmd_ready,
  input  logic         i2c_done,
  input  logic         i2c_nack,
  output logic         busy,
  output logic         seq_done,
  output logic         err_flag,
  output logic [1:0]   err_code,
  input  logic         err_clr
);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH} state_t;

  state_t         state_q, state_d;
  logic [127:0]   data_q, data_d;
  logic [7:0]     base_q, base_d;
  logic [2:0]     cnt_q, cnt_d, k_q, k_d;
  logic           cam_q, cam_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           seq_done_q, err_flag_q;
  logic [1:0]     err_code_q;
  logic           err_rec, fail;
  logic [1:0]     err_val, fail_code;
  logic           map_ok, map_cam;
  logic [7:0]     map_base;
  logic [2:0]     map_cnt;

  always_comb begin
    map_ok   = 1'b1;
    map_cam  = 1'b0;
    map_base = 8'h20;
    map_cnt  = 3'd2;
    case (reg_addr)
      8'h02: ;
      8'h03: map_cam = 1'b1;
      8'h05: begin map_base = 8'h40; map_cnt = 3'd4; end
      8'h06: begin map_base = 8'h40; map_cnt = 3'd4; map_cam = 1'b1; end
      default: begin map_ok = 1'b0; map_base = 8'h00; map_cnt = 3'd0; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    cam_d     = cam_q;
    k_d       = k_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    err_rec   = 1'b0;
    err_val   = 2'd0;
    fail      = 1'b0;
    fail_code = 2'd0;
    case (state_q)
      IDLE: if (instr_valid) begin
        data_d  = reg_data;
        base_d  = map_base;
        cnt_d   = map_cnt;
        cam_d   = map_cam;
        k_d     = '0;
        retry_d = '0;
        tmo_d   = '0;
        if (map_ok) state_d = ISSUE;
        else begin
          state_d = FINISH;
          err_rec = 1'b1;
          err_val = 2'd3;
        end
      end
      ISSUE: if (cmd_ready) begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (i2c_done && !i2c_nack) state_d = NEXT;
        else if (i2c_done) begin fail = 1'b1; fail_code = 2'd1; end
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin fail = 1'b1; fail_code = 2'd2; end
        else tmo_d = tmo_q + TW'(1);
        // retry the same word until the budget is spent, then give up on the rest
        if (fail) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = ISSUE;
          end else begin
            err_rec = 1'b1;
            err_val = fail_code;
            state_d = FINISH;
          end
        end
      end
      NEXT: begin
        k_d     = k_q + 3'd1;
        retry_d = '0;
        state_d = (k_d < cnt_q) ? ISSUE : FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_q    <= IDLE;
      data_q     <= '0;
      base_q     <= '0;
      cnt_q      <= '0;
      cam_q      <= 1'b0;
      k_q        <= '0;
      retry_q    <= '0;
      tmo_q      <= '0;
      seq_done_q <= 1'b0;
      err_flag_q <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      cam_q      <= cam_d;
      k_q        <= k_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
      seq_done_q <= (state_q == FINISH);
      if (err_rec) begin
        err_flag_q <= 1'b1;
        err_code_q <= err_val;
      end else if (err_clr) begin
        err_flag_q <= 1'b0;
        err_code_q <= 2'd0;
      end
    end
  end

  assign instr_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign cmd_valid    = (state_q == ISSUE);
  assign cam_i2c_addr = base_q + {5'd0, k_q};
  assign cam_i2c_data = data_q[{k_q, 4'd0} +: 16];
  assign cam_id       = cam_q;
  assign seq_done     = seq_done_q;
  assign err_flag     = err_flag_q;
  assign err_code     = err_code_q;
endmodule

// File: tb/tb_cam_i2c_cmd_sequencer.sv
// Directed bench: plays the I2C master by hand and checks each write, retry and error path.
module tb_cam_i2c_cmd_sequencer;
  logic         sysClk = 1'b0;
  logic         sysRst_n = 1'b0;
  logic [7:0]   reg_addr = '0;
  logic [127:0] reg_data = '0;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [7:0]   cam_i2c_addr;
  logic [15:0]  cam_i2c_data;
  logic         cam_id;
  logic         cmd_valid;
  logic         cmd_ready = 1'b0;
  logic         i2c_done = 1'b0;
  logic         i2c_nack = 1'b0;
  logic         busy;
  logic         seq_done;
  logic         err_flag;
  logic [1:0]   err_code;
  logic         err_clr = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int hs_by_addr [256] = '{default: 0};

  cam_i2c_cmd_sequencer #(.MAX_RETRY(2), .TIMEOUT_CYC(16)) dut (
    .sysClk(sysClk), .sysRst_n(sysRst_n), .reg_addr(reg_addr), .reg_data(reg_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .cam_i2c_addr(cam_i2c_addr),
    .cam_i2c_data(cam_i2c_data), .cam_id(cam_id), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .i2c_done(i2c_done), .i2c_nack(i2c_nack), .busy(busy), .seq_done(seq_done),
    .err_flag(err_flag), .err_code(err_code), .err_clr(err_clr)
  );

  always #5 sysClk = ~sysClk;

  always @(posedge sysClk)
    if (sysRst_n && cmd_valid && cmd_ready) hs_by_addr[cam_i2c_addr] = hs_by_addr[cam_i2c_addr] + 1;

  task automatic tick();
    @(negedge sysClk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one instruction; returns at the negedge of the cycle after acceptance.
  task automatic send_instr(input string tag, input logic [7:0] a, input logic [127:0] d, input logic clr);
    check({tag, " instr_ready"}, instr_ready, 1);
    reg_addr = a; reg_data = d; instr_valid = 1'b1; err_clr = clr;
    tick();
    instr_valid = 1'b0; err_clr = 1'b0; reg_addr = 8'hFF; reg_data = '1;
  endtask

  task automatic serve_word(input string tag, input logic [7:0] ea, input logic [15:0] ed, input logic ec,
                            input int rdly, input int ddly, input logic nack, input logic nodone);
    int n = 0;
    while (!cmd_valid && n < 40) begin tick(); n++; end
    check({tag, " cmd_valid"}, cmd_valid, 1);
    check({tag, " addr"}, cam_i2c_addr, ea);
    check({tag, " data"}, cam_i2c_data, ed);
    check({tag, " cam_id"}, cam_id, ec);
    for (int i = 0; i < rdly; i++) begin
      tick();
      check({tag, " held valid"}, cmd_valid, 1);
      check({tag, " held addr/data"}, {cam_i2c_addr, cam_i2c_data}, {ea, ed});
    end
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check({tag, " valid drops in wait"}, cmd_valid, 0);
    if (!nodone) begin
      repeat (ddly) tick();
      i2c_done = 1'b1; i2c_nack = nack;
      tick();
      i2c_done = 1'b0; i2c_nack = 1'b0;
    end
  endtask

  task automatic wait_seq_done(input string tag);
    int n = 0;
    while (!seq_done && n < 10) begin tick(); n++; end
    check({tag, " seq_done"}, seq_done, 1);
    check({tag, " idle at seq_done"}, busy, 0);
    tick();
    check({tag, " seq_done one cycle"}, seq_done, 0);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, base41, base42, base43, base20, base21;
    // reset values
    tick();
    check("rst instr_ready", instr_ready, 1);
    check("rst outputs", {cmd_valid, busy, seq_done, err_flag, err_code, cam_id}, 0);
    check("rst addr/data", {cam_i2c_addr, cam_i2c_data}, 0);
    sysRst_n = 1'b1;
    tick();

    // 0x02, all ACK: two cam-1 writes
    send_instr("t1", 8'h02, {96'hDEAD_BEEF_0BAD_F00D_CAFE_0001, 32'h1234_5678}, 1'b0);
    check("t1 latency-1 valid", cmd_valid, 1);
    check("t1 busy", busy, 1);
    serve_word("t1w0", 8'h20, 16'h5678, 1'b0, 0, 2, 1'b0, 1'b0);
    serve_word("t1w1", 8'h21, 16'h1234, 1'b0, 0, 2, 1'b0, 1'b0);
    wait_seq_done("t1");
    check("t1 err_flag", err_flag, 0);

    // 0x06, cmd_ready three cycles late on every word
    send_instr("t2", 8'h06, {64'hFFFF_EEEE_DDDD_CCCC, 64'h4444_3333_2222_1111}, 1'b0);
    serve_word("t2w0", 8'h40, 16'h1111, 1'b1, 3, 1, 1'b0, 1'b0);
    serve_word("t2w1", 8'h41, 16'h2222, 1'b1, 3, 1, 1'b0, 1'b0);
    serve_word("t2w2", 8'h42, 16'h3333, 1'b1, 3, 1, 1'b0, 1'b0);
    serve_word("t2w3", 8'h43, 16'h4444, 1'b1, 3, 1, 1'b0, 1'b0);
    wait_seq_done("t2");
    check("t2 err_flag", err_flag, 0);

    // 0x05, word 1 NACKed on every attempt
    base41 = hs_by_addr[8'h41]; base42 = hs_by_addr[8'h42]; base43 = hs_by_addr[8'h43];
    send_instr("t3", 8'h05, {64'h0, 64'hD3D3_C2C2_B1B1_A0A0}, 1'b0);
    serve_word("t3w0", 8'h40, 16'hA0A0, 1'b0, 0, 1, 1'b0, 1'b0);
    serve_word("t3w1a", 8'h41, 16'hB1B1, 1'b0, 0, 1, 1'b1, 1'b0);
    serve_word("t3w1b", 8'h41, 16'hB1B1, 1'b0, 0, 1, 1'b1, 1'b0);
    serve_word("t3w1c", 8'h41, 16'hB1B1, 1'b0, 0, 1, 1'b1, 1'b0);
    wait_seq_done("t3");
    check("t3 word1 attempts", hs_by_addr[8'h41] - base41, 3);
    check("t3 word2/3 never", (hs_by_addr[8'h42] - base42) + (hs_by_addr[8'h43] - base43), 0);
    check("t3 err", {err_flag, err_code}, {1'b1, 2'd1});
    clear_err();
    check("t3 err_clr", {err_flag, err_code}, 0);

    // no i2c_done: three timed-out attempts
    base20 = hs_by_addr[8'h20]; base21 = hs_by_addr[8'h21];
    send_instr("t4", 8'h02, {96'h0, 32'h7777_BEEF}, 1'b0);
    for (int a = 0; a < 2; a++) begin
      serve_word("t4 try", 8'h20, 16'hBEEF, 1'b0, 0, 0, 1'b0, 1'b1);
      gap = 0;
      while (!cmd_valid && gap < 40) begin tick(); gap++; end
      check("t4 retry gap", gap, 16);
      check("t4 no err yet", err_flag, 0);
    end
    serve_word("t4 last", 8'h20, 16'hBEEF, 1'b0, 0, 0, 1'b0, 1'b1);
    repeat (16) tick();
    check("t4 finish no valid", {cmd_valid, busy}, 2'b01);
    check("t4 err", {err_flag, err_code}, {1'b1, 2'd2});
    tick();
    check("t4 seq_done", seq_done, 1);
    check("t4 attempts", hs_by_addr[8'h20] - base20, 3);
    check("t4 word1 never", hs_by_addr[8'h21] - base21, 0);
    clear_err();

    // unsupported address, err_clr in the recording cycle
    base20 = hs_by_addr[8'h20];
    send_instr("t5", 8'h09, 128'h1, 1'b1);
    check("t5 finish", {cmd_valid, busy, seq_done}, 3'b010);
    check("t5 err beats clr", {err_flag, err_code}, {1'b1, 2'd3});
    tick();
    check("t5 seq_done @2", {seq_done, busy}, 2'b10);
    tick();
    check("t5 seq_done pulse", seq_done, 0);
    check("t5 err kept", {err_flag, err_code}, {1'b1, 2'd3});

    // async reset during WAIT, error still set from previous step
    send_instr("t6", 8'h03, {112'h0, 16'h5A5A}, 1'b0);
    serve_word("t6w0", 8'h20, 16'h5A5A, 1'b1, 0, 0, 1'b0, 1'b1);
    tick();
    #2;
    sysRst_n = 1'b0;
    #1;
    check("t6 async instr_ready", instr_ready, 1);
    check("t6 async ctrl", {cmd_valid, busy, seq_done, err_flag, err_code, cam_id}, 0);
    check("t6 async addr/data", {cam_i2c_addr, cam_i2c_data}, 0);
    tick();
    sysRst_n = 1'b1;
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("t6 late done ignored", {cmd_valid, busy, seq_done, err_flag}, 0);
      tick();
    end
    check("t6 ready after", instr_ready, 1);
    check("t6 no extra writes", hs_by_addr[8'h20] - base20, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cam_i2c_cmd_sequencer.md
CAM_I2C_CMD_SEQUENCER -- requirements
Module: cam_i2c_cmd_sequencer

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 2: retries per I2C word after first attempt fails.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: cycles waited for i2c_done before the attempt counts as failed.
REQ-003 SHALL have port sysClk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port sysRst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port reg_addr, input, 8: camera register-table address of the instruction.
REQ-006 SHALL have port reg_data, input, 128: instruction payload; word k = reg_data[16k+15:16k].
REQ-007 SHALL have port instr_valid, input, 1: instruction present.
REQ-008 SHALL have port instr_ready, output, 1: sequencer can accept an instruction.
REQ-009 SHALL have port cam_i2c_addr, output, 8: I2C register address of the current word.
REQ-010 SHALL have port cam_i2c_data, output, 16: I2C data of the current word.
REQ-011 SHALL have port cam_id, output, 1: target camera (0 = cam 1, 1 = cam 2).
REQ-012 SHALL have port cmd_valid, output, 1: I2C write request to the I2C master.
REQ-013 SHALL have port cmd_ready, input, 1: I2C master accepts the request.
REQ-014 SHALL have port i2c_done, input, 1: one-cycle pulse; the I2C transfer has finished.
REQ-015 SHALL have port i2c_nack, input, 1: qualifies i2c_done; transfer was NACKed.
REQ-016 SHALL have port busy, output, 1: a sequence is in progress.
REQ-017 SHALL have port seq_done, output, 1: one-cycle pulse at the end of every accepted instruction.
REQ-018 SHALL have port err_flag, output, 1: sticky error flag.
REQ-019 SHALL have port err_code, output, 2: last error (0 none, 1 NACK, 2 timeout, 3 unsupported address).
REQ-020 SHALL have port err_clr, input, 1: clears err_flag and err_code.

Function
REQ-021 SHALL map addresses: 0x02 to 2 words, base 0x20, cam 0; 0x03 to 2 words, base 0x20, cam 1; 0x05 to 4 words, base 0x40, cam 0; 0x06 to 4 words, base 0x40, cam 1; any other address is unsupported.
REQ-022 SHALL drive cam_i2c_addr = base + k (8-bit, no wrap is possible) and cam_i2c_data = word k for the current word index k.
REQ-023 SHALL use the states IDLE, ISSUE, WAIT, NEXT and FINISH.
REQ-024 SHALL assert instr_ready only in IDLE; an instruction is accepted on a cycle where instr_valid=1 and instr_ready=1.
REQ-025 SHALL on acceptance latch reg_addr, reg_data and the mapping, set k=0, go to ISSUE, and ignore the inputs until IDLE is re-entered.
REQ-026 SHALL on an unsupported address go directly to FINISH, with err_code=3, without asserting cmd_valid.
REQ-027 SHALL in ISSUE assert cmd_valid, holding addr, data and cam_id stable until cmd_ready; the cycle with cmd_valid and cmd_ready both 1 goes to WAIT and clears the timeout counter.
REQ-028 SHALL in WAIT, on i2c_done with i2c_nack=0, go to NEXT.
REQ-029 SHALL in WAIT treat i2c_done with i2c_nack=1 as a failure with code 1.
REQ-030 SHALL in WAIT treat the timeout counter reaching TIMEOUT_CYC-1 with no i2c_done as a failure with code 2.
REQ-031 SHALL on a failure return to ISSUE for the same word if the retry count is below MAX_RETRY, else record the error and go to FINISH, abandoning the remaining words.
REQ-032 SHALL reset the retry count on every new word.
REQ-033 SHALL in NEXT increment k, going to ISSUE if k is less than the word count, else FINISH.
REQ-034 SHALL in FINISH pulse seq_done for one cycle and return to IDLE.
REQ-035 SHALL ignore i2c_done outside WAIT.
REQ-036 SHALL assert busy in all states except IDLE.
REQ-037 SHALL set err_flag and load err_code on a recorded error.
REQ-038 SHALL clear err_flag and err_code on err_clr; a recorded error wins over err_clr in the same cycle.
REQ-039 SHALL give a minimum latency from acceptance to the first cmd_valid of 1 cycle.

Reset
REQ-040 SHALL while sysRst_n=0 immediately force state IDLE, instr_ready=1, and drive to 0: cmd_valid, busy, seq_done, err_flag, err_code, cam_i2c_addr, cam_i2c_data, cam_id, k, retry and timeout counters.
REQ-041 SHALL on reset mid-sequence abandon the sequence with no seq_done, and ignore any later i2c_done.

Verification
REQ-042 SHALL cover: addr 0x02, data[31:0]=0x1234_5678, all ACK -> writes (0x20,0x5678),(0x21,0x1234), cam_id=0, seq_done, err_flag=0.
REQ-043 SHALL cover: addr 0x06, cmd_ready delayed 3 cycles per word -> 4 writes 0x40..0x43, cam_id=1, cmd_valid and data held stable.
REQ-044 SHALL cover: addr 0x05, word 1 NACKed 3 times -> word 1 issued 3 times, words 2 and 3 never issued, err_code=1.
REQ-045 SHALL cover: no i2c_done, TIMEOUT_CYC=16 -> 3 attempts 16 cycles apart, err_code=2, seq_done.
REQ-046 SHALL cover: addr 0x09 -> no cmd_valid, seq_done 2 cycles after acceptance, err_code=3; err_clr in the same cycle leaves the error set.
REQ-047 SHALL cover: sysRst_n low during WAIT -> all outputs 0 and instr_ready=1 asynchronously; a late i2c_done is ignored.
